// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window controller: pixel/window typedefs, counter width, FSM states.
package sobel_pkg;

  localparam int unsigned PixW = 8;
  // Wide enough for row/col up to 2047.
  localparam int unsigned CntW = 11;

  typedef logic [PixW-1:0] pixel_t;
  typedef pixel_t window_t [0:8];

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StStream,
    StDone
  } state_e;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of delay: read-before-write RAM addressed by the current column.
module sobel_line_buffer #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  assign dout_o = mem_q[addr_i];

endmodule

// File: rtl/sobel_window_ctrl.sv
// Raster pixel stream to 3x3 window controller with a one-window output holding register.
// Optional SOBEL_CTRL_STATS_EN adds win_count and stall_count outputs.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] windowBuffer [0:8],
  output logic             start_calculations,
  input  logic             calc_ready,
  output logic             frame_done
`ifdef SOBEL_CTRL_STATS_EN
  ,
  output logic [21:0]      win_count,
  output logic [15:0]      stall_count
`endif
);

  localparam int unsigned LbAw = $clog2(IMG_W);

  state_e           state_q, state_d;
  logic [CntW-1:0]  col_q, col_d, row_q, row_d;
  logic             start_q, start_d;
  logic             done_q, done_d;
  logic [PIX_W-1:0] win_q [0:8];
  logic [PIX_W-1:0] win_d [0:8];
  // Per window row, the two previously accepted columns: [0] is c-2, [1] is c-1.
  logic [PIX_W-1:0] sh_q [0:2][0:1];
  logic [PIX_W-1:0] col_in [0:2];
  logic [PIX_W-1:0] lb0_out, lb1_out;
  logic             accept, consume, last_col, last_row, win_ok;

  assign pix_ready = (state_q != StDone) && (!start_q || calc_ready);
  assign accept    = pix_valid && pix_ready;
  assign consume   = start_q && calc_ready;
  assign last_col  = (col_q == CntW'(IMG_W - 1));
  assign last_row  = (row_q == CntW'(IMG_H - 1));
  assign win_ok    = (row_q >= CntW'(2)) && (col_q >= CntW'(2));

  assign col_in[0] = lb1_out;
  assign col_in[1] = lb0_out;
  assign col_in[2] = pix_in;

  sobel_line_buffer #(
    .Depth(IMG_W),
    .Width(PIX_W),
    .AddrW(LbAw)
  ) u_lb_row1 (
    .clk_i (clk),
    .we_i  (accept),
    .addr_i(col_q[LbAw-1:0]),
    .din_i (pix_in),
    .dout_o(lb0_out)
  );

  sobel_line_buffer #(
    .Depth(IMG_W),
    .Width(PIX_W),
    .AddrW(LbAw)
  ) u_lb_row2 (
    .clk_i (clk),
    .we_i  (accept),
    .addr_i(col_q[LbAw-1:0]),
    .din_i (lb0_out),
    .dout_o(lb1_out)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    start_d = start_q;
    done_d  = 1'b0;
    win_d   = win_q;

    if (consume) begin
      start_d = 1'b0;
    end
    // A fresh window overrides the consume-clear so start stays high on back-to-back windows.
    if (accept) begin
      col_d = last_col ? '0 : col_q + CntW'(1);
      if (last_col) begin
        row_d = last_row ? '0 : row_q + CntW'(1);
      end
      if (win_ok) begin
        start_d = 1'b1;
        for (int r = 0; r < 3; r++) begin
          win_d[3*r]   = sh_q[r][0];
          win_d[3*r+1] = sh_q[r][1];
          win_d[3*r+2] = col_in[r];
        end
      end
    end

    case (state_q)
      StIdle:   if (accept) state_d = StPrime;
      StPrime:  if (accept && (row_q == CntW'(2)) && (col_q == '0)) state_d = StStream;
      StStream: if (accept && last_row && last_col) state_d = StDone;
      StDone: begin
        if (!start_q || calc_ready) begin
          state_d = StIdle;
          done_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      start_q <= start_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        sh_q[r][0] <= sh_q[r][1];
        sh_q[r][1] <= col_in[r];
      end
    end
  end

  assign windowBuffer       = win_q;
  assign start_calculations = start_q;
  assign frame_done         = done_q;

`ifdef SOBEL_CTRL_STATS_EN
  logic [21:0] win_cnt_q;
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (done_q) begin
        win_cnt_q <= '0;
      end else if (consume) begin
        win_cnt_q <= win_cnt_q + 22'd1;
      end
      if (start_q && !calc_ready && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign win_count   = win_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Randomised bench for sobel_window_ctrl: 4x4 frames against a window scoreboard, plus a 3x3 instance.
module tb_sobel_window_ctrl;
  import sobel_pkg::*;

  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned PW   = 8;
  localparam int unsigned NWIN = (W - 2) * (H - 2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic [PW-1:0] pix_in = '0;
  logic          pix_valid = 1'b0, calc_ready = 1'b0;
  logic          pix_ready, start_calculations, frame_done;
  logic [PW-1:0] windowBuffer [0:8];

  logic [PW-1:0] pix_in3 = '0;
  logic          pix_valid3 = 1'b0, calc_ready3 = 1'b0;
  logic          pix_ready3, start3, frame_done3;
  logic [PW-1:0] win3 [0:8];

`ifdef SOBEL_CTRL_STATS_EN
  logic [21:0] win_count, win_count3;
  logic [15:0] stall_count, stall_count3;
`endif

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk               (clk),
    .rst               (rst),
    .pix_in            (pix_in),
    .pix_valid         (pix_valid),
    .pix_ready         (pix_ready),
    .windowBuffer      (windowBuffer),
    .start_calculations(start_calculations),
    .calc_ready        (calc_ready),
    .frame_done        (frame_done)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .win_count         (win_count),
    .stall_count       (stall_count)
`endif
  );

  sobel_window_ctrl #(.IMG_W(3), .IMG_H(3), .PIX_W(PW)) dut3 (
    .clk               (clk),
    .rst               (rst),
    .pix_in            (pix_in3),
    .pix_valid         (pix_valid3),
    .pix_ready         (pix_ready3),
    .windowBuffer      (win3),
    .start_calculations(start3),
    .calc_ready        (calc_ready3),
    .frame_done        (frame_done3)
`ifdef SOBEL_CTRL_STATS_EN
    ,
    .win_count         (win_count3),
    .stall_count       (stall_count3)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [71:0] win_flat, win3_flat;
  always_comb begin
    win_flat  = '0;
    win3_flat = '0;
    for (int i = 0; i < 9; i++) begin
      win_flat[(8-i)*8 +: 8]  = windowBuffer[i];
      win3_flat[(8-i)*8 +: 8] = win3[i];
    end
  end

  // Reference model: frame image by raster index, queue of windows still owed downstream.
  logic [PW-1:0] frame_pix [W*H];
  logic [71:0]   exp_q [$];
  window_t       exp_w;
  logic [71:0]   exp_e, new_exp, held_w;
  logic          new_win = 1'b0, held_v = 1'b0, fd_prev = 1'b0;
  int            acc_n = 0, win_n = 0, fd_n = 0, mr, mc;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_n   = 0;
      win_n   = 0;
      new_win = 1'b0;
      held_v  = 1'b0;
      fd_prev = 1'b0;
    end else begin
      if (new_win) begin
        check("win_latency", {start_calculations, win_flat}, {1'b1, new_exp});
        new_win = 1'b0;
      end
      if (held_v) check("hold_stable", {start_calculations, win_flat}, {1'b1, held_w});
      if (frame_done) begin
        check("fd_single", fd_prev, 1'b0);
        check("fd_win_total", win_n, NWIN);
        check("fd_pix_total", acc_n, W * H);
        check("fd_queue_empty", exp_q.size(), 0);
`ifdef SOBEL_CTRL_STATS_EN
        check("win_count", win_count, NWIN);
`endif
        fd_n++;
        acc_n = 0;
        win_n = 0;
      end
      fd_prev = frame_done;
      check("pix_ready", pix_ready,
            (!start_calculations || calc_ready) && (acc_n < int'(W * H)));
      if (start_calculations && calc_ready) begin
        if (exp_q.size() == 0) check("spurious_win", start_calculations, 1'b0);
        else begin
          check("win_data", win_flat, exp_q.pop_front());
          win_n++;
        end
      end
      if (pix_valid && pix_ready) begin
        frame_pix[acc_n] = pix_in;
        mr = acc_n / W;
        mc = acc_n % W;
        if (mr >= 2 && mc >= 2) begin
          for (int i = 0; i < 9; i++) exp_w[i] = frame_pix[(mr - 2 + i / 3) * W + mc - 2 + i % 3];
          for (int i = 0; i < 9; i++) exp_e[(8-i)*8 +: 8] = exp_w[i];
          exp_q.push_back(exp_e);
          new_win = 1'b1;
          new_exp = exp_e;
        end
        acc_n++;
      end
      held_v = start_calculations && !calc_ready;
      held_w = win_flat;
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    pix_valid  = 1'b0;
    calc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_start", start_calculations, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_window", win_flat, 72'h0);
    check("rst_pix_ready", pix_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // mode 0 contiguous, 1 five-cycle stall on first window, 2 valid every other cycle,
  // 3 random pixels/valid/ready; abort_at>0 resets after that many pixels are accepted.
  task automatic run_frame(input int mode, input int abort_at);
    int sent = 0, cyc = 0, stalls = 0, fd0 = fd_n;
    int stall_left = (mode == 1) ? 5 : 0;
    while ((fd_n == fd0) && (cyc < 2000)) begin
      pix_valid = (sent < int'(W * H)) &&
                  ((mode == 2) ? (cyc % 2 == 0) : (mode == 3) ? ($urandom_range(0, 3) != 0) : 1'b1);
      pix_in    = (mode == 3) ? 8'($urandom) : 8'(sent);
      if (stall_left > 0 && start_calculations) begin
        calc_ready = 1'b0;
        stall_left--;
        stalls++;
      end else begin
        calc_ready = (mode == 3) ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      @(negedge clk);
      if (pix_valid && pix_ready) sent++;
      @(posedge clk);
      #1 cyc++;
      if (abort_at > 0 && sent == abort_at) begin
        do_reset();
        check("abort_no_fd", fd_n, fd0);
        return;
      end
    end
    pix_valid = 1'b0;
    check("frame_done_seen", fd_n - fd0, 1);
    if (mode == 1) begin
      check("stall_cycles", stalls, 5);
`ifdef SOBEL_CTRL_STATS_EN
      check("stall_count", stall_count, 5);
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);
    run_frame(4, 10);
    run_frame(0, 0);
    for (int f = 0; f < 4; f++) run_frame(3, 0);

    for (int f = 0; f < 2; f++) begin
      int fd_wait = 0;
      calc_ready3 = 1'b1;
      for (int k = 1; k <= 9; k++) begin
        pix_valid3 = 1'b1;
        pix_in3    = 8'(k);
        @(negedge clk);
        check("w3_ready", pix_ready3, 1'b1);
        @(posedge clk);
        #1;
      end
      pix_valid3 = 1'b0;
      @(negedge clk);
      check("w3_window", {start3, win3_flat}, {1'b1, 72'h010203040506070809});
      while (!frame_done3 && fd_wait < 8) begin
        @(posedge clk);
        #1 @(negedge clk);
        fd_wait++;
      end
      check("w3_frame_done", frame_done3, 1'b1);
      check("w3_idle_ready", pix_ready3, 1'b1);
      @(posedge clk);
      #1 @(negedge clk);
      check("w3_fd_pulse", frame_done3, 1'b0);
      check("w3_drained", start3, 1'b0);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_window_ctrl.md
SOBEL_WINDOW_CTRL -- requirements
Module: sobel_window_ctrl

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line, legal range 3..2047.
REQ-002 Parameter IMG_H, default 480, lines per frame, legal range 3..2047.
REQ-003 Parameter PIX_W, default 8, bits per pixel.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1, rising-edge clock for all state.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port pix_in, input, PIX_W, raster-order pixel, top-left first.
REQ-008 Port pix_valid, input, 1, pix_in is valid this cycle.
REQ-009 Port pix_ready, output, 1, block accepts pix_in this cycle.
REQ-010 Port windowBuffer, output, 9 x PIX_W, 3x3 window, row-major; [0..2] is the top row and [6..8] is the bottom row.
REQ-011 Port start_calculations, output, 1, windowBuffer is valid for the gradient units.
REQ-012 Port calc_ready, input, 1, gradient units consume the window this cycle.
REQ-013 Port frame_done, output, 1, single-cycle pulse after the last window of a frame is consumed.

Function
REQ-014 A pixel SHALL be accepted only on a cycle where pix_valid and pix_ready are both 1.
REQ-015 A window SHALL be consumed only on a cycle where start_calculations and calc_ready are both 1.
REQ-016 pix_ready SHALL equal (state != DONE) and (!start_calculations or calc_ready), so at most one window is ever held.
REQ-017 The block SHALL keep counters col (0..IMG_W-1) and row (0..IMG_H-1) of the next pixel to accept; col wraps to 0 and row increments on accepting col = IMG_W-1.
REQ-018 Two line buffers of IMG_W x PIX_W SHALL hold rows row-1 and row-2; a 3-column shift register per row SHALL form the window.
REQ-019 Accepting pixel (r,c) with r>=2 and c>=2 SHALL load windowBuffer with pixels (r-2..r, c-2..c) and assert start_calculations on the next cycle; latency is 1 cycle.
REQ-020 No window SHALL be produced for r<2 or c<2; there is no border padding; a frame yields exactly (IMG_W-2)*(IMG_H-2) windows.
REQ-021 windowBuffer and start_calculations SHALL hold steady while start_calculations=1 and calc_ready=0.
REQ-022 If a window is consumed on the same cycle a new pixel is accepted, the new window SHALL replace the old one with start_calculations remaining 1.
REQ-023 The FSM SHALL have states IDLE, PRIME, STREAM, and DONE.
REQ-024 IDLE -> PRIME on the first accepted pixel.
REQ-025 PRIME -> STREAM on accepting pixel (2,0).
REQ-026 STREAM -> DONE on accepting pixel (IMG_H-1, IMG_W-1).
REQ-027 DONE SHALL wait for the final window to be consumed, pulse frame_done for 1 cycle, clear row and col, then return to IDLE.
REQ-028 When IMG_H = 3, PRIME, STREAM, and DONE SHALL each be traversed in order.
REQ-029 Line-buffer contents are don't-care at a frame start; rows 0..1 rewrite them before use.

Reset
REQ-030 On rst=1 at a clock edge: state=IDLE, row=col=0, start_calculations=0, frame_done=0, windowBuffer=0, and pix_ready=1 on the following cycle.
REQ-031 Reset mid-frame SHALL abandon the frame and discard any held window without a calc_ready handshake; no frame_done pulse is generated.
REQ-032 Line-buffer RAM contents SHALL NOT require reset.

Configuration
REQ-033 Macro SOBEL_CTRL_STATS_EN.
REQ-034 When SOBEL_CTRL_STATS_EN is defined, output win_count [21:0] SHALL increment on every consumed window, clear on rst, and clear on the cycle after a frame_done pulse.
REQ-035 When SOBEL_CTRL_STATS_EN is defined, output stall_count [15:0] SHALL increment each cycle that start_calculations=1 and calc_ready=0, and saturate at 16'hFFFF.
REQ-036 When SOBEL_CTRL_STATS_EN is undefined, win_count, stall_count, and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 Package sobel_pkg SHALL hold the pixel_t typedef (PIX_W bits), the window_t typedef (array [0:8] of pixel_t), and the FSM state enum.
REQ-038 Sub-module sobel_line_buffer SHALL be one IMG_W-deep, single-write, single-read delay line, instantiated twice.
REQ-039 The RTL SHALL contain no arithmetic on pixel values; gradient math stays in the downstream units.

Verification (IMG_W=4, IMG_H=4 unless stated)
REQ-040 Stream pixels 0..15 with calc_ready=1 -> exactly 4 windows; the first window is {0,1,2,4,5,6,8,9,10}, asserted 1 cycle after pixel 10 is accepted.
REQ-041 Hold calc_ready=0 for 5 cycles on the first window -> pix_ready=0, window stable, no pixel accepted; release -> streaming resumes with no window lost.
REQ-042 Toggle pix_valid every other cycle -> window contents identical to the contiguous case, and frame_done pulses exactly once.
REQ-043 Assert rst after pixel 9 -> outputs reach reset values; the next frame 0..15 yields the same 4 windows as REQ-040.
REQ-044 IMG_W=3, IMG_H=3 with pixels 1..9 -> one window {1..9}, then frame_done, and the FSM returns to IDLE.
REQ-045 With SOBEL_CTRL_STATS_EN defined, run REQ-041 -> stall_count=5 and win_count=4 before frame_done.
